fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 25 ++
 rtl/pc_next_sel.sv | 35 +++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode constants, fetch FSM encoding, reset vector.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_pkg;

  // Primary opcode field values (instr[31:26]) consumed by the control unit.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // First fetch address after reset unless the instance overrides it.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch FSM: IDLE (post-reset bubble), REQ (memory read outstanding),
  // HOLD (instruction presented to the decoder).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-pc selection: sequential increment and redirect target (jump over branch).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the selected value is loaded.
// Ports: pc/pc_out in; jump+jump_index, branch_taken+branch_target in;
//        pc_inc, redirect, redirect_pc out.
module pc_next_sel (
  input  logic [31:0] pc,
  input  logic [31:0] pc_out,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_inc,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic [31:0] pc_out_inc;
  logic [31:0] jump_pc;
  logic        unused_bits;

  always_comb begin
    // Wraps naturally modulo 2^32.
    pc_inc      = pc + 32'd4;
    // The jump region comes from the delay-slot address of the held instruction.
    pc_out_inc  = pc_out + 32'd4;
    jump_pc     = {pc_out_inc[31:28], jump_index, 2'b00};
    redirect    = jump | branch_taken;
    // Jump wins when both are raised; branch targets are forced word aligned.
    redirect_pc = jump ? jump_pc : {branch_target[31:2], 2'b00};
  end

  assign unused_bits = ^{branch_target[1:0], pc_out_inc[27:0]};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues imem reads at pc and holds each fetched word for the decoder.
// Latency: instr_valid rises exactly one cycle after the accepted imem_ack.
// Backpressure: instr_ready=0 freezes the held instruction and stops new requests.
// Ports: clk/reset; imem_req/imem_addr out, imem_ack/imem_rdata in;
//        instr/opcode/pc_out/instr_valid out, instr_ready in;
//        jump/jump_index and branch_taken/branch_target redirect inputs.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  fetch_state_t state, state_nxt;

  logic [31:0] pc, pc_nxt;
  logic        kill, kill_nxt;
  logic        capture;
  logic        drop_vld;

  logic [31:0] pc_inc;
  logic        redirect;
  logic [31:0] redirect_pc;

  pc_next_sel u_pc_next_sel (
    .pc            (pc),
    .pc_out        (pc_out),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_inc        (pc_inc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      instr       <= 32'd0;
      pc_out      <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      kill  <= kill_nxt;
      if (capture) begin
        instr       <= imem_rdata;
        pc_out      <= pc;
        instr_valid <= 1'b1;
      end else if (drop_vld) begin
        instr_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    capture   = 1'b0;
    drop_vld  = 1'b0;
    imem_req  = 1'b0;

    unique case (state)
      // One bubble after reset; any late ack or redirect here is ignored.
      IDLE: state_nxt = REQ;

      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_nxt = redirect_pc;
          // If the read completes this same cycle its data is simply dropped and
          // nothing is left in flight; otherwise the in-flight read must be killed.
          kill_nxt = ~imem_ack;
        end else if (imem_ack) begin
          if (kill) begin
            // Stale read for the pre-redirect pc: discard and reissue at pc.
            kill_nxt = 1'b0;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          drop_vld  = 1'b1;
          state_nxt = REQ;
        end else if (instr_ready) begin
          pc_nxt    = pc_inc;
          drop_vld  = 1'b1;
          state_nxt = REQ;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } pres_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [31:0] branch_target;

  int checks;
  int failures;

  logic [31:0] req_q[$];
  pres_t       pres_q[$];

  int          ack_delay;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory contents: ADDI with the low address bits, plus one LW at address 8.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h8C01_0004;
    return {6'b001000, a[25:0]};
  endfunction

  task automatic push_req(input logic [31:0] a);
    req_q.push_back(a);
  endtask

  task automatic push_pres(input logic [31:0] p, input logic [31:0] w);
    pres_t e;
    e.pc   = p;
    e.word = w;
    pres_q.push_back(e);
  endtask

  // Instruction memory responder: latches a new request whenever idle and
  // returns data ack_delay cycles later; every request address is scoreboarded.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    mem_busy   = 1'b0;
    mem_cnt    = 0;
    mem_addr   = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(mem_addr);
          mem_busy   = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else begin
        imem_ack = 1'b0;
        if (imem_req === 1'b1) begin
          mem_addr = imem_addr;
          mem_busy = 1'b1;
          mem_cnt  = ack_delay;
          if (req_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected actual=%h required=none", imem_addr);
          end else begin
            check32("req_addr", imem_addr, req_q.pop_front());
          end
        end
      end
    end
  end

  // Presentation monitor: each new instr_valid episode must match the next
  // expected instruction, and must stay stable while it is held.
  initial begin
    logic  prev_vld;
    pres_t cur;
    prev_vld = 1'b0;
    cur.pc   = 32'd0;
    cur.word = 32'd0;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        if (!prev_vld) begin
          if (pres_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pres_unexpected actual=%h/%h required=none", pc_out, instr);
          end else begin
            cur = pres_q.pop_front();
            check32("pres_pc", pc_out, cur.pc);
            check32("pres_instr", instr, cur.word);
            check32("pres_opcode", {26'd0, opcode}, {26'd0, cur.word[31:26]});
          end
        end else begin
          check32("held_pc", pc_out, cur.pc);
          check32("held_instr", instr, cur.word);
        end
      end
      prev_vld = (instr_valid === 1'b1);
    end
  end

  task automatic wait_present(input logic [31:0] p);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && pc_out === p) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_present_timeout actual=none required=%h", p);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    ack_delay     = 0;
    reset         = 1'b1;
    instr_ready   = 1'b0;
    jump          = 1'b0;
    jump_index    = 26'd0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check32("rst_req", {31'd0, imem_req}, 32'd0);
    check32("rst_vld", {31'd0, instr_valid}, 32'd0);
    check32("rst_instr", instr, 32'd0);
    check32("rst_pc_out", pc_out, 32'd0);

    // Sequential fetch 0, 4, 8 with ready held high; stop on 8.
    push_req(32'h0000_0000); push_pres(32'h0000_0000, 32'h2000_0000);
    push_req(32'h0000_0004); push_pres(32'h0000_0004, 32'h2000_0004);
    push_req(32'h0000_0008); push_pres(32'h0000_0008, 32'h8C01_0004);
    reset       = 1'b0;
    instr_ready = 1'b1;
    wait_present(32'h0000_0008);
    instr_ready = 1'b0;

    // Backpressure: LW held stable, no requests for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("stall_instr", instr, 32'h8C01_0004);
      check32("stall_opcode", {26'd0, opcode}, 32'h0000_0023);
      check32("stall_pc_out", pc_out, 32'h0000_0008);
      check32("stall_req", {31'd0, imem_req}, 32'd0);
    end

    // Advance to 0x10 and jump from HOLD with ready low.
    push_req(32'h0000_000C); push_pres(32'h0000_000C, 32'h2000_000C);
    push_req(32'h0000_0010); push_pres(32'h0000_0010, 32'h2000_0010);
    instr_ready = 1'b1;
    wait_present(32'h0000_0010);
    instr_ready = 1'b0;
    push_req(32'h0000_0100); push_pres(32'h0000_0100, 32'h2000_0100);
    jump       = 1'b1;
    jump_index = 26'h000_0040;
    @(negedge clk);
    jump = 1'b0;
    wait_present(32'h0000_0100);

    // Branch while a slow read is outstanding: stale 0x104 data must be dropped.
    ack_delay = 3;
    push_req(32'h0000_0104);
    push_req(32'h0000_0200); push_pres(32'h0000_0200, 32'h2000_0200);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0203;
    @(negedge clk);
    branch_taken = 1'b0;
    wait_present(32'h0000_0200);

    // Jump and branch together: jump target 0x240 wins over 0x300.
    ack_delay = 0;
    push_req(32'h0000_0240); push_pres(32'h0000_0240, 32'h2000_0240);
    jump          = 1'b1;
    jump_index    = 26'h000_0090;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0300;
    @(negedge clk);
    jump         = 1'b0;
    branch_taken = 1'b0;
    wait_present(32'h0000_0240);

    // Wrap: branch to the top word, then sequential fetch wraps to 0.
    push_req(32'hFFFF_FFFC); push_pres(32'hFFFF_FFFC, 32'h23FF_FFFC);
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    @(negedge clk);
    branch_taken = 1'b0;
    wait_present(32'hFFFF_FFFC);
    push_req(32'h0000_0000); push_pres(32'h0000_0000, 32'h2000_0000);
    instr_ready = 1'b1;
    wait_present(32'h0000_0000);
    instr_ready = 1'b0;

    // Reset mid-request: the ack lands while in IDLE and must be ignored.
    push_req(32'h0000_0004);
    push_req(32'h0000_0000); push_pres(32'h0000_0000, 32'h2000_0000);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check32("midrst_vld", {31'd0, instr_valid}, 32'd0);
    check32("midrst_req", {31'd0, imem_req}, 32'd0);
    check32("midrst_instr", instr, 32'd0);
    check32("midrst_pc_out", pc_out, 32'd0);
    wait_present(32'h0000_0000);

    repeat (5) @(negedge clk);
    check32("req_q_left", req_q.size(), 32'd0);
    check32("pres_q_left", pres_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
